// File: rtl/param_updown_counter_pkg.sv
// Shared types and constants for the parametrised up/down counter.
package param_updown_counter_pkg;

    // Direction encoding kept from the fixed +/-1 counter this block replaces.
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } udc_dir_e;

    localparam int unsigned UDC_WRAP = 0;
    localparam int unsigned UDC_SAT  = 1;

    typedef struct packed {
        logic ovf;
        logic unf;
    } udc_evt_t;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle between the counter and its host.
interface param_updown_counter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STEP_W = 8
);
    logic              enable;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic [WIDTH-1:0]  lo_limit;
    logic [WIDTH-1:0]  hi_limit;
    logic              clear_flags;

    logic [WIDTH-1:0]  value;
    logic              ovf_pulse;
    logic              unf_pulse;
    logic              ovf_sticky;
    logic              unf_sticky;
    logic              at_hi;
    logic              at_lo;
    logic              cfg_err;

    modport master (
        output enable, dir, step, load, load_value, lo_limit, hi_limit, clear_flags,
        input  value, ovf_pulse, unf_pulse, ovf_sticky, unf_sticky, at_hi, at_lo, cfg_err
    );

    modport slave (
        input  enable, dir, step, load, load_value, lo_limit, hi_limit, clear_flags,
        output value, ovf_pulse, unf_pulse, ovf_sticky, unf_sticky, at_hi, at_lo, cfg_err
    );
endinterface

// File: rtl/udc_step_unit.sv
// Combinational next-value computation for one enabled count step,
// including limit compare and wrap/saturate selection.
module udc_step_unit
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned SATURATE = UDC_WRAP
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [STEP_W-1:0] step,
    input  udc_dir_e          dir,
    input  logic [WIDTH-1:0]  lo_limit,
    input  logic [WIDTH-1:0]  hi_limit,
    output logic [WIDTH-1:0]  next_value_c,
    output udc_evt_t          evt_c
);
    localparam int unsigned EXT_W = WIDTH + 1;

    logic [EXT_W-1:0] step_ext;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] diff;
    logic [EXT_W-1:0] hi_ext;
    logic             borrow;

    // Extra top bit catches carry out of an up step and borrow out of a down step.
    always_comb begin
        step_ext     = EXT_W'(step);
        hi_ext       = {1'b0, hi_limit};
        sum          = {1'b0, value} + step_ext;
        diff         = {1'b0, value} - step_ext;
        borrow       = diff[WIDTH];
        next_value_c = value;
        evt_c        = '0;

        // A zero step is a hold, even when value sits outside the limits.
        if (step != '0) begin
            if (dir == DIR_UP) begin
                if (sum <= hi_ext) begin
                    next_value_c = sum[WIDTH-1:0];
                end else begin
                    evt_c.ovf    = 1'b1;
                    next_value_c = (SATURATE == UDC_SAT) ? hi_limit : lo_limit;
                end
            end else begin
                if (!borrow && (diff[WIDTH-1:0] >= lo_limit)) begin
                    next_value_c = diff[WIDTH-1:0];
                end else begin
                    evt_c.unf    = 1'b1;
                    next_value_c = (SATURATE == UDC_SAT) ? lo_limit : hi_limit;
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable step, runtime limits, parallel load and
// overflow/underflow pulses plus sticky flags.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned    WIDTH     = 32,
    parameter int unsigned    STEP_W    = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned    SATURATE  = UDC_WRAP
) (
    input  logic                  clock,
    input  logic                  reset,
    param_updown_counter_if.slave bus
);
    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic             unf_pulse_q, unf_pulse_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;

    logic [WIDTH-1:0] step_next_c;
    udc_evt_t         step_evt_c;
    udc_dir_e         dir_c;
    logic             cfg_err_c;

    assign dir_c     = udc_dir_e'(bus.dir);
    assign cfg_err_c = (bus.lo_limit > bus.hi_limit);

    udc_step_unit #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .SATURATE (SATURATE)
    ) u_step (
        .value        (value_q),
        .step         (bus.step),
        .dir          (dir_c),
        .lo_limit     (bus.lo_limit),
        .hi_limit     (bus.hi_limit),
        .next_value_c (step_next_c),
        .evt_c        (step_evt_c)
    );

    // Priority: load > config-error hold > enabled count > hold (reset is in the register).
    always_comb begin
        value_d      = value_q;
        ovf_pulse_d  = 1'b0;
        unf_pulse_d  = 1'b0;
        ovf_sticky_d = ovf_sticky_q & ~bus.clear_flags;
        unf_sticky_d = unf_sticky_q & ~bus.clear_flags;

        if (bus.load) begin
            value_d = bus.load_value;
        end else if (!cfg_err_c && bus.enable) begin
            value_d     = step_next_c;
            ovf_pulse_d = step_evt_c.ovf;
            unf_pulse_d = step_evt_c.unf;
            // A new event beats a simultaneous clear.
            if (step_evt_c.ovf) begin
                ovf_sticky_d = 1'b1;
            end
            if (step_evt_c.unf) begin
                unf_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q      <= RESET_VAL;
            ovf_pulse_q  <= 1'b0;
            unf_pulse_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            value_q      <= value_d;
            ovf_pulse_q  <= ovf_pulse_d;
            unf_pulse_q  <= unf_pulse_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.ovf_pulse  = ovf_pulse_q;
    assign bus.unf_pulse  = unf_pulse_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.unf_sticky = unf_sticky_q;
    assign bus.at_hi      = (value_q == bus.hi_limit);
    assign bus.at_lo      = (value_q == bus.lo_limit);
    assign bus.cfg_err    = cfg_err_c;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share the stimulus;
// each cycle pushes the hand-computed expectation for the selected instance.
module tb_param_updown_counter;

    logic clock;
    logic reset;

    param_updown_counter_if #(.WIDTH(8), .STEP_W(4)) bus_w ();
    param_updown_counter_if #(.WIDTH(8), .STEP_W(4)) bus_s ();

    param_updown_counter #(
        .WIDTH(8), .STEP_W(4), .RESET_VAL(8'h00), .SATURATE(0)
    ) u_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w.slave)
    );

    param_updown_counter #(
        .WIDTH(8), .STEP_W(4), .RESET_VAL(8'h00), .SATURATE(1)
    ) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Flag order: ovf_pulse, unf_pulse, ovf_sticky, unf_sticky, at_hi, at_lo, cfg_err.
    typedef struct {
        bit         sel;
        string      name;
        logic [7:0] value;
        logic [6:0] flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] act_flags_w, act_flags_s;
    assign act_flags_w = {bus_w.ovf_pulse, bus_w.unf_pulse, bus_w.ovf_sticky, bus_w.unf_sticky,
                          bus_w.at_hi, bus_w.at_lo, bus_w.cfg_err};
    assign act_flags_s = {bus_s.ovf_pulse, bus_s.unf_pulse, bus_s.ovf_sticky, bus_s.unf_sticky,
                          bus_s.at_hi, bus_s.at_lo, bus_s.cfg_err};

    // Monitor: outputs settle after each posedge; compare one expectation per cycle.
    initial begin
        exp_t       e;
        logic [7:0] av;
        logic [6:0] af;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                av = e.sel ? bus_s.value : bus_w.value;
                af = e.sel ? act_flags_s : act_flags_w;
                checks++;
                if ((av !== e.value) || (af !== e.flags)) begin
                    errors++;
                    $display("FAIL %s: got value=%0d flags=%b, expected value=%0d flags=%b",
                             e.name, av, af, e.value, e.flags);
                end
            end
        end
    end

    task automatic drive_both(input bit ld, input logic [7:0] lv, input bit en, input bit dn,
                              input logic [3:0] st, input logic [7:0] lo, input logic [7:0] hi,
                              input bit clr);
        bus_w.load = ld; bus_w.load_value = lv; bus_w.enable = en; bus_w.dir = dn;
        bus_w.step = st; bus_w.lo_limit = lo; bus_w.hi_limit = hi; bus_w.clear_flags = clr;
        bus_s.load = ld; bus_s.load_value = lv; bus_s.enable = en; bus_s.dir = dn;
        bus_s.step = st; bus_s.lo_limit = lo; bus_s.hi_limit = hi; bus_s.clear_flags = clr;
    endtask

    // One cycle: apply inputs, push expectation (ef = ovf_p, unf_p, ovf_s, unf_s).
    task automatic cyc(input string name, input bit sel, input bit rst, input bit ld,
                       input logic [7:0] lv, input bit en, input bit dn, input logic [3:0] st,
                       input logic [7:0] lo, input logic [7:0] hi, input bit clr,
                       input logic [7:0] ev, input logic [3:0] ef);
        exp_t e;
        reset = rst;
        drive_both(ld, lv, en, dn, st, lo, hi, clr);
        e.sel   = sel;
        e.name  = name;
        e.value = ev;
        e.flags = {ef, (ev == hi), (ev == lo), (lo > hi)};
        sb.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        drive_both(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd255, 1'b0);
        @(negedge clock);

        //   name                 sel rst ld lv      en dn st     lo      hi       clr ev      ef
        cyc("reset_w",            0,  1,  0, 8'd0,   0, 0, 4'd0,  8'd0,   8'd255,  0,  8'd0,   4'b0000);
        cyc("reset_s",            1,  1,  0, 8'd0,   0, 0, 4'd0,  8'd0,   8'd255,  0,  8'd0,   4'b0000);
        cyc("load18",             0,  0,  1, 8'd18,  0, 0, 4'd0,  8'd10,  8'd20,   0,  8'd18,  4'b0000);
        cyc("wrap_up_ovf",        0,  0,  0, 8'd0,   1, 0, 4'd3,  8'd10,  8'd20,   0,  8'd10,  4'b1010);
        cyc("ovf_pulse_1cyc",     0,  0,  0, 8'd0,   0, 0, 4'd0,  8'd10,  8'd20,   0,  8'd10,  4'b0010);
        cyc("up5",                0,  0,  0, 8'd0,   1, 0, 4'd5,  8'd10,  8'd20,   0,  8'd15,  4'b0010);
        cyc("up5_to_hi",          0,  0,  0, 8'd0,   1, 0, 4'd5,  8'd10,  8'd20,   0,  8'd20,  4'b0010);
        cyc("dn4",                0,  0,  0, 8'd0,   1, 1, 4'd4,  8'd10,  8'd20,   0,  8'd16,  4'b0010);
        cyc("wrap_dn_unf",        0,  0,  0, 8'd0,   1, 1, 4'd7,  8'd10,  8'd20,   0,  8'd20,  4'b0111);
        cyc("step0_hold",         0,  0,  0, 8'd0,   1, 0, 4'd0,  8'd10,  8'd20,   0,  8'd20,  4'b0011);
        cyc("clear_flags",        0,  0,  0, 8'd0,   0, 0, 4'd0,  8'd10,  8'd20,   1,  8'd20,  4'b0000);
        cyc("ovf_beats_clear",    0,  0,  0, 8'd0,   1, 0, 4'd1,  8'd10,  8'd20,   1,  8'd10,  4'b1010);
        cyc("clear_alone",        0,  0,  0, 8'd0,   0, 0, 4'd0,  8'd10,  8'd20,   1,  8'd10,  4'b0000);
        cyc("load_above_hi",      0,  0,  1, 8'd30,  0, 0, 4'd0,  8'd10,  8'd20,   0,  8'd30,  4'b0000);
        cyc("step0_outside",      0,  0,  0, 8'd0,   1, 0, 4'd0,  8'd10,  8'd20,   0,  8'd30,  4'b0000);
        cyc("above_hi_up_ovf",    0,  0,  0, 8'd0,   1, 0, 4'd1,  8'd10,  8'd20,   0,  8'd10,  4'b1010);
        cyc("load_below_lo",      0,  0,  1, 8'd3,   0, 0, 4'd0,  8'd10,  8'd20,   0,  8'd3,   4'b0010);
        cyc("below_lo_dn_unf",    0,  0,  0, 8'd0,   1, 1, 4'd1,  8'd10,  8'd20,   0,  8'd20,  4'b0111);
        cyc("clear_with_load",    0,  0,  1, 8'd2,   0, 0, 4'd0,  8'd0,   8'd20,   1,  8'd2,   4'b0000);
        cyc("borrow_unf",         0,  0,  0, 8'd0,   1, 1, 4'd3,  8'd0,   8'd20,   0,  8'd20,  4'b0101);
        cyc("load_beats_enable",  0,  0,  1, 8'h7F,  1, 0, 4'd3,  8'd0,   8'd255,  0,  8'h7F,  4'b0001);
        cyc("reset_beats_load",   0,  1,  1, 8'h55,  1, 0, 4'd3,  8'd0,   8'd255,  0,  8'd0,   4'b0000);
        cyc("load_fe",            0,  0,  1, 8'hFE,  0, 0, 4'd0,  8'd0,   8'd255,  0,  8'hFE,  4'b0000);
        cyc("carry_out_ovf",      0,  0,  0, 8'd0,   1, 0, 4'd3,  8'd0,   8'd255,  0,  8'd0,   4'b1010);
        for (int i = 0; i < 5; i++) begin
            cyc("cfg_err_hold",   0,  0,  0, 8'd0,   1, 0, 4'd1,  8'd30,  8'd20,   0,  8'd0,   4'b0010);
        end
        cyc("cfg_err_load",       0,  0,  1, 8'd25,  0, 0, 4'd0,  8'd30,  8'd20,   0,  8'd25,  4'b0010);
        cyc("cfg_err_dn_hold",    0,  0,  0, 8'd0,   1, 1, 4'd4,  8'd30,  8'd20,   0,  8'd25,  4'b0010);
        cyc("sat_reset",          1,  1,  0, 8'd0,   0, 0, 4'd0,  8'd5,   8'd200,  0,  8'd0,   4'b0000);
        cyc("sat_load6",          1,  0,  1, 8'd6,   0, 0, 4'd0,  8'd5,   8'd200,  0,  8'd6,   4'b0000);
        cyc("sat_dn_unf",         1,  0,  0, 8'd0,   1, 1, 4'd4,  8'd5,   8'd200,  0,  8'd5,   4'b0101);
        cyc("sat_dn_unf_again",   1,  0,  0, 8'd0,   1, 1, 4'd4,  8'd5,   8'd200,  0,  8'd5,   4'b0101);
        cyc("sat_idle",           1,  0,  0, 8'd0,   0, 0, 4'd0,  8'd5,   8'd200,  0,  8'd5,   4'b0001);
        cyc("sat_load198",        1,  0,  1, 8'd198, 0, 0, 4'd0,  8'd5,   8'd200,  0,  8'd198, 4'b0001);
        cyc("sat_up_ovf",         1,  0,  0, 8'd0,   1, 0, 4'd4,  8'd5,   8'd200,  0,  8'd200, 4'b1011);
        cyc("sat_up_ovf_again",   1,  0,  0, 8'd0,   1, 0, 4'd4,  8'd5,   8'd200,  0,  8'd200, 4'b1011);
        cyc("sat_step0",          1,  0,  0, 8'd0,   1, 0, 4'd0,  8'd5,   8'd200,  0,  8'd200, 4'b0011);
        cyc("sat_dn15",           1,  0,  0, 8'd0,   1, 1, 4'd15, 8'd5,   8'd200,  0,  8'd185, 4'b0011);
        cyc("hi_change_up4",      1,  0,  0, 8'd0,   1, 0, 4'd4,  8'd5,   8'd190,  0,  8'd189, 4'b0011);
        cyc("hi_change_ovf",      1,  0,  0, 8'd0,   1, 0, 4'd4,  8'd5,   8'd190,  0,  8'd190, 4'b1011);

        drive_both(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd5, 8'd190, 1'b0);
        repeat (4) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
